// File: rtl/integer_mul_add_pkg.sv
`default_nettype none
// ============================================================================
// Module      : integer_mul_add_pkg
// Description : Shared constants for the shift-add multiply-accumulate block.
// Revision    : 1.0 - initial release
// ============================================================================
package integer_mul_add_pkg;

   localparam int DEFAULT_WIDTH = 16;

endpackage
`default_nettype wire

// File: rtl/integer_shift_add.sv
`default_nettype none
// ============================================================================
// Module      : integer_shift_add
// Description : Upper-half accumulator slice; conditionally adds mcand to hi
//               and shifts the sum right, handing its LSB down to the lo reg.
// Revision    : 1.0 - initial release
// ============================================================================
module integer_shift_add #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             step,
   input  logic [WIDTH-1:0] addend,
   input  logic [WIDTH-1:0] mcand,
   input  logic             lo_lsb,
   output logic [WIDTH-1:0] hi,
   output logic             shift_in
);

   logic [WIDTH-1:0] r_hi;
   logic [WIDTH-1:0] w_addend_sel;
   logic [WIDTH:0]   w_sum;

   assign w_addend_sel = lo_lsb ? mcand : '0;
   assign w_sum        = {1'b0, r_hi} + {1'b0, w_addend_sel};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_hi <= '0;
      end else if (load) begin
         r_hi <= addend;
      end else if (step) begin
         // Carry lands in the MSB; bit 0 of the sum moves into lo.
         r_hi <= w_sum[WIDTH:1];
      end
   end

   assign hi       = r_hi;
   assign shift_in = w_sum[0];

endmodule
`default_nettype wire

// File: rtl/integer_mul_add.sv
`default_nettype none
// ============================================================================
// Module      : integer_mul_add
// Description : Sequential unsigned result = multiplicand*multiplier + addend,
//               WIDTH steps, level-sensitive start/rdy handshake.
// Revision    : 1.0 - initial release
// ============================================================================
import integer_mul_add_pkg::*;

module integer_mul_add #(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [WIDTH-1:0]   multiplicand,
   input  logic [WIDTH-1:0]   multiplier,
   input  logic [WIDTH-1:0]   addend,
   output logic [2*WIDTH-1:0] result,
   output logic               rdy
);

   localparam int                  CNT_WIDTH   = $clog2(WIDTH);
   localparam logic [CNT_WIDTH-1:0] c_last_step = CNT_WIDTH'(WIDTH - 1);
   localparam logic [CNT_WIDTH-1:0] c_cnt_one   = CNT_WIDTH'(1);

   logic [WIDTH-1:0]     r_lo;
   logic [WIDTH-1:0]     r_mcand;
   logic [CNT_WIDTH-1:0] r_cnt;
   logic                 r_rdy;
   logic [WIDTH-1:0]     w_hi;
   logic                 w_shift_in;
   logic                 w_load;
   logic                 w_step;

   assign w_load = ~start;
   assign w_step = start & ~r_rdy;

   integer_shift_add #(
      .WIDTH (WIDTH)
   ) u_shift_add (
      .clk      (clk),
      .rst      (rst),
      .load     (w_load),
      .step     (w_step),
      .addend   (addend),
      .mcand    (r_mcand),
      .lo_lsb   (r_lo[0]),
      .hi       (w_hi),
      .shift_in (w_shift_in)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_lo    <= '0;
         r_mcand <= '0;
         r_cnt   <= '0;
         r_rdy   <= 1'b0;
      end else if (w_load) begin
         r_lo    <= multiplier;
         r_mcand <= multiplicand;
         r_cnt   <= '0;
         r_rdy   <= 1'b0;
      end else if (w_step) begin
         r_lo  <= {w_shift_in, r_lo[WIDTH-1:1]};
         r_cnt <= r_cnt + c_cnt_one;
         // The last multiplier bit is consumed on this edge, so the product is final.
         if (r_cnt == c_last_step) begin
            r_rdy <= 1'b1;
         end
      end
   end

   assign result = {w_hi, r_lo};
   assign rdy    = r_rdy;

endmodule
`default_nettype wire

// File: tb/tb_integer_mul_add.sv
`default_nettype none
// ============================================================================
// Module      : tb_integer_mul_add
// Description : Self-checking bench for integer_mul_add at WIDTH=8.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_integer_mul_add;

   localparam int W = 8;

   logic           clk;
   logic           rst;
   logic           start;
   logic [W-1:0]   multiplicand;
   logic [W-1:0]   multiplier;
   logic [W-1:0]   addend;
   logic [2*W-1:0] result;
   logic           rdy;

   int n_cmp;
   int n_err;

   integer_mul_add #(
      .WIDTH (W)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .multiplicand (multiplicand),
      .multiplier   (multiplier),
      .addend       (addend),
      .result       (result),
      .rdy          (rdy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Load with start=0 for one edge, then run exactly W edges with start=1.
   task automatic do_mul(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c,
                         input bit check_lat, input string tag);
      int unsigned expv;
      expv         = int'(a) * int'(b) + int'(c);
      start        = 1'b0;
      multiplicand = a;
      multiplier   = b;
      addend       = c;
      tick();
      start = 1'b1;
      for (int i = 1; i <= W; i++) begin
         tick();
         if (check_lat && i < W) check({tag, "_rdy_early"}, 32'(rdy), 32'd0);
      end
      check({tag, "_rdy"}, 32'(rdy), 32'd1);
      check({tag, "_result"}, 32'(result), expv);
   endtask

   initial begin
      int unsigned a_r, b_r, c_r, prod;
      logic [2*W-1:0] held;

      n_cmp = 0;
      n_err = 0;
      rst   = 1'b0;
      start = 1'b0;
      multiplicand = '0;
      multiplier   = '0;
      addend       = '0;
      repeat (3) tick();
      check("reset_result", 32'(result), 32'd0);
      check("reset_rdy", 32'(rdy), 32'd0);
      rst = 1'b1;
      tick();

      // Basic case, with latency and hold checks.
      do_mul(8'd13, 8'd11, 8'd5, 1'b1, "basic");
      held = result;
      for (int i = 0; i < 20; i++) begin
         multiplicand = 8'($urandom);
         multiplier   = 8'($urandom);
         addend       = 8'($urandom);
         tick();
         if (i % 5 == 0) begin
            check("hold_result", 32'(result), 32'd148);
            check("hold_rdy", 32'(rdy), 32'd1);
         end
      end
      check("hold_final", 32'(result), 32'(held));

      // rdy falls one edge after start drops.
      start = 1'b0;
      tick();
      check("drop_after_rdy", 32'(rdy), 32'd0);

      do_mul(8'd255, 8'd255, 8'd255, 1'b1, "max_all");
      do_mul(8'd255, 8'd255, 8'd0,   1'b0, "max_noadd");
      do_mul(8'd0,   8'd200, 8'd7,   1'b1, "mcand_zero");
      do_mul(8'd200, 8'd0,   8'd0,   1'b0, "mplier_zero");

      // Abort after 3 steps, reload different operands.
      start = 1'b0;
      multiplicand = 8'd13; multiplier = 8'd11; addend = 8'd5;
      tick();
      start = 1'b1;
      repeat (3) tick();
      check("abort_rdy_mid", 32'(rdy), 32'd0);
      do_mul(8'd3, 8'd4, 8'd1, 1'b1, "reload");

      // Asynchronous reset mid-operation.
      start = 1'b0;
      multiplicand = 8'd13; multiplier = 8'd11; addend = 8'd5;
      tick();
      start = 1'b1;
      repeat (4) tick();
      #2 rst = 1'b0;
      #1;
      check("async_rst_result", 32'(result), 32'd0);
      check("async_rst_rdy", 32'(rdy), 32'd0);
      tick();
      rst = 1'b1;
      do_mul(8'd2, 8'd3, 8'd0, 1'b0, "post_rst");

      // Random round-trip: dividing the result by a must give back b and c.
      for (int k = 0; k < 1000; k++) begin
         a_r = $urandom_range(255, 1);
         b_r = $urandom_range(255, 0);
         c_r = $urandom_range(a_r - 1, 0);
         do_mul(8'(a_r), 8'(b_r), 8'(c_r), 1'b0, "rand");
         prod = 32'(result);
         check("rand_quot", prod / a_r, b_r);
         check("rand_rem",  prod % a_r, c_r);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
